// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: in-order word fetch, DEPTH-entry prefetch FIFO, redirect squash.
// Define FETCH_STATS_EN to add the stat_fetched / stat_squashed word counters.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_squashed
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];

  logic        credit_ok, req_fire, drop, push, pop;
  logic [31:0] redirect_aligned, rsp_pc_plus4;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign rsp_pc_plus4     = rsp_pc_q + 32'd4;
  // Buffered plus in-flight words never exceed DEPTH, so a response always finds a free slot.
  assign credit_ok = ({1'b0, fifo_count_q} + {1'b0, outstanding_q}) < DEPTH_C;

  assign imem_req_valid = reset && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign if_valid       = (fifo_count_q != '0);
  assign if_instr       = instr_mem_q[rd_ptr_q];
  assign if_pc_plus4    = pc4_mem_q[rd_ptr_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign drop     = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
  assign push     = imem_rsp_valid && !drop;
  assign pop      = if_valid && if_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    fifo_count_d  = fifo_count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_aligned;
      rsp_pc_d      = redirect_aligned;
      fifo_count_d  = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(imem_rsp_valid);
      drop_cnt_d    = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (drop) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_plus4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      fifo_count_q  <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc4_mem_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      fifo_count_q  <= fifo_count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= imem_rsp_data;
        pc4_mem_q[wr_ptr_q]   <= rsp_pc_plus4;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_squashed_q, stat_squashed_d;

  always_comb begin
    stat_fetched_d  = stat_fetched_q + 32'(push);
    stat_squashed_d = stat_squashed_q + 32'(drop);
    if (redirect_valid) stat_squashed_d = stat_squashed_d + 32'(fifo_count_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched_q  <= '0;
      stat_squashed_q <= '0;
    end else begin
      stat_fetched_q  <= stat_fetched_d;
      stat_squashed_q <= stat_squashed_d;
    end
  end

  assign stat_fetched  = stat_fetched_q;
  assign stat_squashed = stat_squashed_q;
`endif

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    push |-> (fifo_count_q != CW'(DEPTH)));
  a_outstanding_bound: assert property (@(posedge clk) disable iff (!reset)
    outstanding_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: table vectors for redirect targets, directed corner sequences,
// and a randomized run checked against an epoch-tagged queue model of the fetch stream.
module tb_fetch_prefetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc_plus4;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_squashed;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_squashed  (stat_squashed)
`endif
  );

  typedef struct { logic [31:0] addr; int unsigned epoch; longint due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } word_t;
  typedef struct { logic [31:0] rpc; logic [31:0] addr0; logic [31:0] addr1; logic [31:0] pc4; } vec_t;

  req_t        mem_q[$];
  word_t       fifo_m[$];
  logic [31:0] exp_req_pc;
  int unsigned epoch;
  longint      cyc, last_due;
  int unsigned exp_fetched, exp_squashed;
  int          n_checks, n_fail, n_req_fired, n_pops;

  logic        k_ready, k_if_ready, k_redirect;
  logic [31:0] k_rpc;
  int          k_lat;

  logic        s_req_valid, s_if_valid, s_rsp;
  logic [31:0] s_req_addr, s_if_pc4, s_if_instr;

  vec_t vecs[3];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at mid-cycle, advance the model after the edge.
  task automatic step();
    logic  rsp, fire, popd;
    int    sz;
    req_t  r;
    word_t w;
    longint due;
    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imem_req_ready = k_ready;
    if_ready       = k_if_ready;
    redirect_valid = k_redirect;
    redirect_pc    = k_rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : 32'h0BAD_F00D;
    #4;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc4    = if_pc_plus4;
    s_if_instr  = if_instr;
    s_rsp       = rsp;
    sz = fifo_m.size() + mem_q.size();
    chk("req_valid", 32'(imem_req_valid), 32'((sz < DEPTH) && !k_redirect));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
    chk("if_valid", 32'(if_valid), 32'(fifo_m.size() != 0));
    if (fifo_m.size() != 0) begin
      chk("if_instr", if_instr, fifo_m[0].instr);
      chk("if_pc_plus4", if_pc_plus4, fifo_m[0].pc4);
    end
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, exp_fetched);
    chk("stat_squashed", stat_squashed, exp_squashed);
`endif
    fire = imem_req_valid && k_ready;
    popd = if_valid && k_if_ready && !k_redirect;
    @(posedge clk);
    #1;
    if (k_redirect) begin
      exp_squashed += fifo_m.size() + (rsp ? 1 : 0);
      fifo_m.delete();
      epoch++;
      exp_req_pc = {k_rpc[31:2], 2'b00};
      if (rsp) r = mem_q.pop_front();
    end else begin
      if (popd) begin
        n_pops++;
        if (fifo_m.size() != 0) w = fifo_m.pop_front();
      end
      if (rsp) begin
        r = mem_q.pop_front();
        if (r.epoch == epoch) begin
          w.instr = mem_word(r.addr);
          w.pc4   = r.addr + 32'd4;
          fifo_m.push_back(w);
          exp_fetched++;
        end else begin
          exp_squashed++;
        end
      end
      if (fire) begin
        due = cyc + longint'(k_lat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr  = exp_req_pc;
        r.epoch = epoch;
        r.due   = due;
        mem_q.push_back(r);
        exp_req_pc = exp_req_pc + 32'd4;
        n_req_fired++;
      end
    end
    cyc++;
  endtask

  // Asserts reset between edges, checks the asynchronous reset values, then releases.
  task automatic do_reset();
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'd0);
    chk("rst_stat_squashed", stat_squashed, 32'd0);
`endif
    mem_q.delete();
    fifo_m.delete();
    exp_req_pc   = RESET_PC;
    epoch++;
    last_due     = cyc;
    exp_fetched  = 0;
    exp_squashed = 0;
    k_redirect   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc4, input logic [31:0] exp_addr);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_if_valid) found = 1;
    end
    if (!found) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_pc4"}, s_if_pc4, exp_pc4);
      chk({name, "_instr"}, s_if_instr, mem_word(exp_addr));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{rpc: 32'hFFFF_FFFC, addr0: 32'hFFFF_FFFC, addr1: 32'h0000_0000, pc4: 32'h0000_0000};
    vecs[1] = '{rpc: 32'h0040_0101, addr0: 32'h0040_0100, addr1: 32'h0040_0104, pc4: 32'h0040_0104};
    vecs[2] = '{rpc: 32'h7FFF_FFFE, addr0: 32'h7FFF_FFFC, addr1: 32'h8000_0000, pc4: 32'h8000_0000};

    n_checks = 0; n_fail = 0; n_req_fired = 0; n_pops = 0;
    cyc = 0; epoch = 0; last_due = 0;
    reset = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    k_ready = 1'b1; k_if_ready = 1'b1; k_redirect = 1'b0; k_rpc = '0; k_lat = 1;
    repeat (2) @(posedge clk);
    #1;

    // Streaming with 1-cycle memory and no stalls.
    do_reset();
    step();
    chk("t1_first_req_valid", 32'(s_req_valid), 32'd1);
    chk("t1_first_req_addr", s_req_addr, RESET_PC);
    step();
    step();
    chk("t1_first_if_valid", 32'(s_if_valid), 32'd1);
    chk("t1_first_pc4", s_if_pc4, 32'h0040_0004);
    repeat (4) step();
    base = n_pops;
    repeat (6) step();
    chk("t1_steady_rate", 32'(n_pops - base), 32'd6);

    // Decode stall fills the FIFO and stops requests at DEPTH.
    do_reset();
    k_if_ready = 1'b0;
    base = n_req_fired;
    repeat (20) step();
    chk("t2_req_count", 32'(n_req_fired - base), 32'(DEPTH));
    chk("t2_req_valid_off", 32'(s_req_valid), 32'd0);
    chk("t2_if_valid", 32'(s_if_valid), 32'd1);
    k_if_ready = 1'b1;
    base = n_pops;
    repeat (12) step();
    chk("t2_drained", 32'(n_pops - base >= DEPTH), 32'd1);

    // Redirect with two words in flight and one buffered, latency 3.
    do_reset();
    k_lat = 3; k_if_ready = 1'b0;
    k_ready = 1'b1; step();
    k_ready = 1'b0; step(); step();
    k_ready = 1'b1; step(); step();
    k_redirect = 1'b1; k_rpc = 32'h0040_0100;
    step();
    chk("t3_buffered_before", 32'(s_if_valid), 32'd1);
    k_redirect = 1'b0; k_if_ready = 1'b1;
    step();
    chk("t3_empty_after", 32'(s_if_valid), 32'd0);
    chk("t3_new_req_addr", s_req_addr, 32'h0040_0100);
    wait_first("t3_first", 32'h0040_0104, 32'h0040_0100);

    // Redirect coinciding with a response and a head pop.
    do_reset();
    k_lat = 1; k_ready = 1'b1; k_if_ready = 1'b1;
    repeat (6) step();
    k_redirect = 1'b1; k_rpc = 32'h0040_0200;
    step();
    chk("t4_rsp_same_cycle", 32'(s_rsp), 32'd1);
    chk("t4_head_same_cycle", 32'(s_if_valid), 32'd1);
    k_redirect = 1'b0;
    step();
    chk("t4_empty_1", 32'(s_if_valid), 32'd0);
    step();
    chk("t4_empty_2", 32'(s_if_valid), 32'd0);
    wait_first("t4_first", 32'h0040_0204, 32'h0040_0200);

    // Table of redirect targets: alignment and address wrap.
    for (int v = 0; v < 3; v++) begin
      k_ready = 1'b1; k_if_ready = 1'b1; k_lat = 1;
      k_redirect = 1'b1; k_rpc = vecs[v].rpc;
      step();
      k_redirect = 1'b0;
      step();
      chk("tv_addr0", s_req_addr, vecs[v].addr0);
      step();
      chk("tv_addr1", s_req_addr, vecs[v].addr1);
      if (s_if_valid) chk("tv_pc4", s_if_pc4, vecs[v].pc4);
      else wait_first("tv_first", vecs[v].pc4, vecs[v].addr0);
    end

    // Reset mid-stream with three words outstanding.
    do_reset();
    k_lat = 4; k_ready = 1'b1; k_if_ready = 1'b1;
    repeat (3) step();
    chk("t6_outstanding", 32'(mem_q.size() == 3 && n_req_fired > 0), 32'd1);
    do_reset();
    k_lat = 1;
    step();
    chk("t6_restart_addr", s_req_addr, RESET_PC);
    chk("t6_restart_valid", 32'(s_req_valid), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      k_ready    = ($urandom % 4) != 0;
      k_if_ready = ($urandom % 10) < 7;
      k_redirect = ($urandom % 32) == 0;
      k_rpc      = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      k_lat      = 1 + int'($urandom % 4);
      step();
    end
    k_redirect = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
